life_pattern_loader: RTL
========================

LIFE_PATTERN_LOADER -- requirements
Module: life_pattern_loader

Interface
REQ-001 SHALL have a single clock domain and a synchronous, active-low reset: reset_n is sampled only on the rising edge of ph1.
REQ-002 SHALL have the following ports:
- ph1  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  synchronous reset, active low.
- start  in  1  begin a board load (pulse).
- bit_valid  in  1  bit_in is valid this cycle.
- bit_in  in  1  serial pattern data.
- ready  out  1  loader accepts a bit this cycle.
- mem_we  out  1  board-memory write request.
- mem_addr  out  3  row address of the write.
- mem_data  out  8  row pattern; bit n = column n.
- mem_grant  in  1  memory accepts a write this cycle (the controller is not reading).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when all 8 rows are committed.
- err  out  1  one-cycle pulse on checksum mismatch.

Function
REQ-003 SHALL implement the FSM IDLE -> SHIFT -> CHECK -> COMMIT -> DONE -> IDLE.
REQ-004 IDLE: start=1 SHALL enter SHIFT; the bit counter and row buffer clear; bit_valid is ignored.
REQ-005 SHIFT: ready=1; a bit is accepted on a cycle with bit_valid&ready.
REQ-006 Stream format SHALL be 72 bits: rows 0..7 (64 bits), then an 8-bit check byte.
- Each byte is MSB first: the first bit lands in bit 7.
REQ-007 The 7-bit bit counter SHALL count 0..71; acceptance of bit 71 moves to CHECK on the next edge.
REQ-008 start asserted during SHIFT SHALL restart the load: counter=0, buffer cleared, remain in SHIFT, and the bit_in of that cycle is discarded.
REQ-009 CHECK SHALL last exactly one cycle and compare the XOR of the 8 buffered rows with the check byte.
- Match -> COMMIT.
- Mismatch -> err=1 for one cycle, return to IDLE, zero memory writes.
REQ-010 COMMIT: mem_we=1, mem_addr=row index (starting at 0), mem_data=buffer[row index].
REQ-011 A row write SHALL complete on a cycle with mem_we&mem_grant; the row index then increments.
- mem_addr and mem_data are held stable while mem_grant=0.
REQ-012 Completion of the write to row 7 SHALL move to DONE; DONE asserts done=1 for one cycle, then returns to IDLE.
REQ-013 start during CHECK, COMMIT or DONE SHALL be ignored.
REQ-014 Latency: the last stream bit to first mem_we SHALL be 2 cycles; with mem_grant held high, first mem_we to done SHALL be 8 cycles.
REQ-015 ready SHALL be 0 in every state except SHIFT; mem_we SHALL be 0 in every state except COMMIT.

Reset
REQ-016 When reset_n=0 at a ph1 edge, the block SHALL enter IDLE with all outputs 0 (ready, mem_we, mem_addr=3'b000, mem_data=8'h00, busy, done, err) and the counter, row index and buffer cleared.
REQ-017 Reset mid-SHIFT or mid-COMMIT SHALL abort immediately.
- No further writes are issued.
- Rows already written stay in memory.

Structure
REQ-018 Shared package life_pkg SHALL hold ROWS=8, COLS=8, row_t (logic [COLS-1:0]), and the loader state enum.
REQ-019 Serial-to-parallel conversion SHALL be a sub-module life_shift_rx (8-bit MSB-first deserialiser with byte_valid output).
- The loader instantiates it once.

Verification
REQ-020 Glider load: rows 20,10,70,00,00,00,00,00 (hex), check byte 40, mem_grant=1.
- Required: 8 writes, addr 0..7 with matching data; done exactly 8 cycles after first mem_we; err never asserted.
REQ-021 Bad checksum: same rows with check byte 41.
- Required: err pulse 1 cycle after the last bit; zero mem_we; busy low on the next cycle.
REQ-022 Grant stall: glider load with mem_grant=0 for 5 cycles at row 2.
- Required: mem_addr=2 and mem_data=70 held stable; the row 2 write completes only when grant returns.
REQ-023 Restart: 30 bits sent, start pulsed, then a full valid stream.
- Required: only the second stream is committed.
REQ-024 Gapped input: bit_valid toggled randomly, all-ones board with check byte 00.
- Required: 8 writes of FF.
REQ-025 Reset mid-COMMIT after row 3 is written.
- Required: all outputs 0 next cycle; no write to rows 4..7; start then begins a clean load.

Source files
------------

// File: rtl/life_pkg.sv
// Shared constants and types for the Game-of-Life board loader.
// No logic here; geometry, row type and loader state encoding only.
package life_pkg;

  localparam int ROWS        = 8;
  localparam int COLS        = 8;
  // Board rows followed by one check byte.
  localparam int STREAM_BITS = ROWS * COLS + COLS;

  typedef logic [COLS-1:0] row_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CHECK,
    S_COMMIT,
    S_DONE
  } loader_state_t;

endpackage

// File: rtl/life_shift_rx.sv
// Serial-to-parallel deserialiser, MSB first: the first bit of a byte lands in bit 7.
// Latency: byte_vld/byte_dat are combinational on the cycle the 8th bit is presented.
// Backpressure: none; the caller gates bit_vld, and clear drops any partial byte.
module life_shift_rx
  import life_pkg::*;
(
  input  logic ph1,
  input  logic reset_n,
  input  logic clear,
  input  logic bit_vld,
  input  logic bit_dat,
  output logic byte_vld,
  output row_t byte_dat
);

  logic [COLS-2:0] shreg;
  logic [2:0]      cnt;

  // The counter wraps to 0 after the 8th bit; stale shreg bits are shifted out
  // before the next byte completes.
  always_ff @(posedge ph1) begin
    if (!reset_n || clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (bit_vld) begin
      shreg <= {shreg[COLS-3:0], bit_dat};
      cnt   <= cnt + 3'd1;
    end
  end

  assign byte_vld = bit_vld && (cnt == 3'd7);
  assign byte_dat = {shreg, bit_dat};

endmodule

// File: rtl/life_pattern_loader.sv
// Loads an 8x8 board from a serial stream, verifies its XOR check byte, then writes rows to memory.
// Latency: last stream bit to first mem_we is 2 cycles; 8 write cycles to done with grant held high.
// Backpressure: ready is high only while shifting; a row write holds until mem_grant accepts it.
module life_pattern_loader
  import life_pkg::*;
(
  input  logic       ph1,
  input  logic       reset_n,
  input  logic       start,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic       ready,
  output logic       mem_we,
  output logic [2:0] mem_addr,
  output logic [7:0] mem_data,
  input  logic       mem_grant,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [6:0] LAST_BIT = 7'(STREAM_BITS - 1);

  loader_state_t state;
  logic [6:0]    bit_cnt;
  logic [2:0]    row_idx;
  logic [2:0]    row_nxt;
  row_t          buffer [ROWS];
  row_t          xor_acc;

  logic load_init;
  logic rx_clear;
  logic rx_vld;
  logic byte_vld;
  row_t byte_dat;

  // start both opens a load from IDLE and restarts one mid-SHIFT; the bit of that cycle is dropped.
  assign load_init = start && (state == S_IDLE || state == S_SHIFT);
  assign rx_clear  = (state != S_SHIFT) || start;
  assign rx_vld    = (state == S_SHIFT) && bit_valid && !start;
  assign row_nxt   = row_idx + 3'd1;

  life_shift_rx u_rx (
    .ph1      (ph1),
    .reset_n  (reset_n),
    .clear    (rx_clear),
    .bit_vld  (rx_vld),
    .bit_dat  (bit_in),
    .byte_vld (byte_vld),
    .byte_dat (byte_dat)
  );

  // Row buffer plus a running XOR so the check byte compares the cycle it completes.
  always_ff @(posedge ph1) begin
    if (!reset_n || load_init) begin
      bit_cnt <= '0;
      xor_acc <= '0;
      for (int i = 0; i < ROWS; i++) buffer[i] <= '0;
    end else if (rx_vld) begin
      bit_cnt <= bit_cnt + 7'd1;
      if (byte_vld && !bit_cnt[6]) begin
        buffer[bit_cnt[5:3]] <= byte_dat;
        xor_acc              <= xor_acc ^ byte_dat;
      end
    end
  end

  always_ff @(posedge ph1) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      row_idx  <= '0;
      ready    <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_SHIFT;
            ready <= 1'b1;
            busy  <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (rx_vld && bit_cnt == LAST_BIT) begin
            state <= S_CHECK;
            ready <= 1'b0;
            err   <= (byte_dat != xor_acc);
          end
        end
        // err was computed on entry, so it is visible for exactly this one cycle.
        S_CHECK: begin
          if (err) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state    <= S_COMMIT;
            row_idx  <= '0;
            mem_we   <= 1'b1;
            mem_addr <= '0;
            mem_data <= buffer[0];
          end
        end
        S_COMMIT: begin
          if (mem_grant) begin
            if (row_idx == 3'(ROWS - 1)) begin
              state    <= S_DONE;
              mem_we   <= 1'b0;
              mem_addr <= '0;
              mem_data <= '0;
              done     <= 1'b1;
            end else begin
              row_idx  <= row_nxt;
              mem_addr <= row_nxt;
              mem_data <= buffer[row_nxt];
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
